// File: rtl/uart_tx.sv
// UART transmitter: takes a word over valid/ready and shifts it out LSB first with
// start, optional parity and stop bits. Every output comes straight from a flop.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;

    assign bit_end = (cyc_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        if (state_q != StIdle) begin
            cyc_d = bit_end ? '0 : cyc_q + CW'(1);
        end

        case (state_q)
            StIdle: begin
                // ready_q mirrors StIdle, so valid alone means acceptance here
                if (tx_valid) begin
                    state_d  = StStart;
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ 1'(PARITY_ODD);
                    cyc_d    = '0;
                    bit_d    = '0;
                end
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                // bit counter is reused to count stop bits
                if (bit_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is decided one cycle ahead so tx can be a plain flop
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;

endmodule
